rv_realigner: RTL and testbench



---
 rtl/rv16_decoder.sv | 113 +++++++++++
 rtl/rv_realigner.sv | 119 +++++++++++
 tb/tb_rv_realigner.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rv16_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rv16_decoder
// Purpose  : Expands an RV32C compressed parcel into its 32-bit equivalent.
// Revision : 1.0 - initial release
// ============================================================================
module rv16_decoder (
  input  logic [31:0] inst_i,
  output logic [31:0] inst_o,
  output logic        rv16_err_o
);
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;

  logic [15:0] c;
  logic [4:0]  rdp;
  logic [4:0]  rs1p;
  logic [11:0] imm6;
  logic [19:0] jimm;

  assign c    = inst_i[15:0];
  assign rdp  = {2'b01, c[4:2]};
  assign rs1p = {2'b01, c[9:7]};
  assign imm6 = {{6{c[12]}}, c[12], c[6:2]};
  assign jimm = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12], {8{c[12]}}};

  // Anything not listed (including FP loads/stores) is reported as illegal.
  always_comb begin
    inst_o     = inst_i;
    rv16_err_o = 1'b0;
    case (c[1:0])
      2'b00: begin
        case (c[15:13])
          3'b000: begin
            inst_o     = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, OP_IMM};
            rv16_err_o = (c[12:5] == 8'd0);
          end
          3'b010:  inst_o = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, LOAD};
          3'b110:  inst_o = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, STORE};
          default: begin inst_o = 32'b0; rv16_err_o = 1'b1; end
        endcase
      end
      2'b01: begin
        case (c[15:13])
          3'b000: inst_o = {imm6, c[11:7], 3'b000, c[11:7], OP_IMM};
          3'b001: inst_o = {jimm, 5'd1, JAL};
          3'b010: inst_o = {imm6, 5'd0, 3'b000, c[11:7], OP_IMM};
          3'b011: begin
            rv16_err_o = ({c[12], c[6:2]} == 6'd0);
            if (c[11:7] == 5'd2)
              inst_o = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0, 5'd2, 3'b000, 5'd2, OP_IMM};
            else
              inst_o = {{15{c[12]}}, c[6:2], c[11:7], LUI};
          end
          3'b100: begin
            case (c[11:10])
              2'b00: begin inst_o = {7'b0, c[6:2], rs1p, 3'b101, rs1p, OP_IMM}; rv16_err_o = c[12]; end
              2'b01: begin inst_o = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OP_IMM}; rv16_err_o = c[12]; end
              2'b10: inst_o = {imm6, rs1p, 3'b111, rs1p, OP_IMM};
              default: begin
                rv16_err_o = c[12];
                case (c[6:5])
                  2'b00:   inst_o = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_REG};
                  2'b01:   inst_o = {7'b0, rdp, rs1p, 3'b100, rs1p, OP_REG};
                  2'b10:   inst_o = {7'b0, rdp, rs1p, 3'b110, rs1p, OP_REG};
                  default: inst_o = {7'b0, rdp, rs1p, 3'b111, rs1p, OP_REG};
                endcase
              end
            endcase
          end
          3'b101:  inst_o = {jimm, 5'd0, JAL};
          default: inst_o = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 2'b00, c[13],
                             c[11:10], c[4:3], c[12], BRANCH};
        endcase
      end
      2'b10: begin
        case (c[15:13])
          3'b000: begin inst_o = {7'b0, c[6:2], c[11:7], 3'b001, c[11:7], OP_IMM}; rv16_err_o = c[12]; end
          3'b010: begin
            inst_o     = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, c[11:7], LOAD};
            rv16_err_o = (c[11:7] == 5'd0);
          end
          3'b100: begin
            if (!c[12]) begin
              if (c[6:2] == 5'd0) begin
                inst_o     = {12'b0, c[11:7], 3'b000, 5'd0, JALR};
                rv16_err_o = (c[11:7] == 5'd0);
              end else begin
                inst_o = {7'b0, c[6:2], 5'd0, 3'b000, c[11:7], OP_REG};
              end
            end else if (c[11:2] == 10'd0) begin
              inst_o = 32'h0010_0073;
            end else if (c[6:2] == 5'd0) begin
              inst_o = {12'b0, c[11:7], 3'b000, 5'd1, JALR};
            end else begin
              inst_o = {7'b0, c[6:2], c[11:7], 3'b000, c[11:7], OP_REG};
            end
          end
          3'b110:  inst_o = {4'b0, c[8:7], c[12], c[6:2], 5'd2, 3'b010, c[11:9], 2'b00, STORE};
          default: begin inst_o = 32'b0; rv16_err_o = 1'b1; end
        endcase
      end
      default: ;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/rv_realigner.sv
`default_nettype none
// ============================================================================
// Module   : rv_realigner
// Purpose  : Turns 32-bit fetch words of mixed 16/32-bit parcels into one
//            expanded instruction per cycle for decode.
// Revision : 1.0 - initial release
// ============================================================================
module rv_realigner #(
  parameter int PC_W = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  input  logic [31:0]     fetch_data_i,
  input  logic [PC_W-1:0] fetch_pc_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_o,
  output logic [PC_W-1:0] inst_pc_o,
  output logic            inst_rv16_o,
  output logic            inst_illegal_o,
  output logic            seq_err_o
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] HALF  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [15:0]     par_q, par_d;
  logic [PC_W-1:0] par_pc_q, par_pc_d;
  logic [15:0]     parcel;
  logic [31:0]     raw;
  logic [31:0]     dec_inst;
  logic            dec_err;
  logic            is_c;
  logic            lo_is_c;
  logic            par_is_c;

  assign lo_is_c  = (fetch_data_i[1:0] != 2'b11);
  assign par_is_c = (par_q[1:0] != 2'b11);
  assign parcel   = (state_q == HALF) ? par_q : fetch_data_i[15:0];

  rv16_decoder u_rv16_decoder (
    .inst_i     ({16'b0, parcel}),
    .inst_o     (dec_inst),
    .rv16_err_o (dec_err)
  );

  assign inst_o         = is_c ? dec_inst : raw;
  assign inst_rv16_o    = is_c;
  assign inst_illegal_o = is_c & dec_err;

  // inst_valid_o is derived only from state and fetch inputs, never from fetch_ready_o.
  always_comb begin
    state_d       = state_q;
    par_d         = par_q;
    par_pc_d      = par_pc_q;
    inst_valid_o  = 1'b0;
    fetch_ready_o = 1'b0;
    seq_err_o     = 1'b0;
    is_c          = 1'b0;
    raw           = fetch_data_i;
    inst_pc_o     = par_pc_q;
    if (!rst_i) begin
      if (flush_i) begin
        fetch_ready_o = 1'b1;
        state_d       = EMPTY;
        par_d         = 16'b0;
      end else if (state_q == EMPTY) begin
        inst_pc_o = fetch_pc_i;
        if (fetch_valid_i) begin
          if (fetch_pc_i[1]) begin
            fetch_ready_o = 1'b1;
            state_d       = HALF;
            par_d         = fetch_data_i[31:16];
            par_pc_d      = fetch_pc_i;
          end else begin
            inst_valid_o  = 1'b1;
            fetch_ready_o = inst_ready_i;
            is_c          = lo_is_c;
            if (lo_is_c && inst_ready_i) begin
              state_d  = HALF;
              par_d    = fetch_data_i[31:16];
              par_pc_d = fetch_pc_i + PC_W'(2);
            end
          end
        end
      end else if (par_is_c) begin
        inst_valid_o = 1'b1;
        is_c         = 1'b1;
        if (inst_ready_i) state_d = EMPTY;
      end else if (fetch_valid_i) begin
        // Straddle: held parcel is the low half, new word's low parcel the high half.
        inst_valid_o  = 1'b1;
        raw           = {fetch_data_i[15:0], par_q};
        fetch_ready_o = inst_ready_i;
        seq_err_o     = (fetch_pc_i != par_pc_q + PC_W'(2));
        if (inst_ready_i) begin
          par_d    = fetch_data_i[31:16];
          par_pc_d = par_pc_q + PC_W'(4);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= EMPTY;
      par_q    <= 16'b0;
      par_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      par_q    <= par_d;
      par_pc_q <= par_pc_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rv_realigner.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_realigner
// Purpose  : Directed self-checking bench for rv_realigner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_realigner;
  logic        clk = 1'b0;
  logic        rst, flush, fetch_valid, inst_ready;
  logic [31:0] fetch_data, fetch_pc;
  logic        fetch_ready, inst_valid, inst_rv16, inst_illegal, seq_err;
  logic [31:0] inst, inst_pc;
  int          errors = 0;
  int          checks = 0;
  logic [4:0]  flags;

  assign flags = {inst_valid, fetch_ready, inst_rv16, inst_illegal, seq_err};

  always #5 clk = ~clk;

  rv_realigner #(.PC_W(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .fetch_valid_i  (fetch_valid),
    .fetch_ready_o  (fetch_ready),
    .fetch_data_i   (fetch_data),
    .fetch_pc_i     (fetch_pc),
    .inst_valid_o   (inst_valid),
    .inst_ready_i   (inst_ready),
    .inst_o         (inst),
    .inst_pc_o      (inst_pc),
    .inst_rv16_o    (inst_rv16),
    .inst_illegal_o (inst_illegal),
    .seq_err_o      (seq_err)
  );

  // Inputs change at the falling edge; outputs are observed 1ns later.
  task automatic drive(input logic r, input logic f, input logic fv,
                       input logic [31:0] d, input logic [31:0] pc, input logic rdy);
    @(negedge clk);
    rst = r; flush = f; fetch_valid = fv; fetch_data = d; fetch_pc = pc; inst_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 32'h0000_0513, 32'h0, 1);
    checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL reset_flags0: got %b want %b", flags, 5'b00000); end
    drive(1, 0, 1, 32'h0000_0513, 32'h0, 1);
    checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL reset_flags1: got %b want %b", flags, 5'b00000); end
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL reset_empty: got %b want %b", flags, 5'b00000); end
  endtask

  task automatic test_two_compressed();
    drive(0, 0, 1, 32'h4501_4505, 32'h8000_0000, 1);
    checks++; if (flags !== 5'b11100) begin errors++; $display("FAIL two_c0_flags: got %b want %b", flags, 5'b11100); end
    checks++; if ({inst, inst_pc} !== {32'h0010_0513, 32'h8000_0000}) begin errors++; $display("FAIL two_c0_inst: got %h@%h want 00100513@80000000", inst, inst_pc); end
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    checks++; if (flags !== 5'b10100) begin errors++; $display("FAIL two_c1_flags: got %b want %b", flags, 5'b10100); end
    checks++; if ({inst, inst_pc} !== {32'h0000_0513, 32'h8000_0002}) begin errors++; $display("FAIL two_c1_inst: got %h@%h want 00000513@80000002", inst, inst_pc); end
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL two_c_empty: got %b want %b", flags, 5'b00000); end
  endtask

  task automatic test_straddle();
    drive(0, 0, 1, 32'h0513_4505, 32'h100, 1);
    checks++; if (flags !== 5'b11100) begin errors++; $display("FAIL strad0_flags: got %b want %b", flags, 5'b11100); end
    checks++; if ({inst, inst_pc} !== {32'h0010_0513, 32'h100}) begin errors++; $display("FAIL strad0_inst: got %h@%h want 00100513@00000100", inst, inst_pc); end
    drive(0, 0, 1, 32'h4501_0010, 32'h104, 1);
    checks++; if (flags !== 5'b11000) begin errors++; $display("FAIL strad1_flags: got %b want %b", flags, 5'b11000); end
    checks++; if ({inst, inst_pc} !== {32'h0010_0513, 32'h102}) begin errors++; $display("FAIL strad1_inst: got %h@%h want 00100513@00000102", inst, inst_pc); end
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    checks++; if (flags !== 5'b10100) begin errors++; $display("FAIL strad2_flags: got %b want %b", flags, 5'b10100); end
    checks++; if ({inst, inst_pc} !== {32'h0000_0513, 32'h106}) begin errors++; $display("FAIL strad2_inst: got %h@%h want 00000513@00000106", inst, inst_pc); end
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL strad_empty: got %b want %b", flags, 5'b00000); end
  endtask

  task automatic test_halfword_redirect();
    drive(0, 0, 1, 32'h4505_FFFF, 32'h202, 1);
    checks++; if (flags !== 5'b01000) begin errors++; $display("FAIL redir_dead_flags: got %b want %b", flags, 5'b01000); end
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    checks++; if (flags !== 5'b10100) begin errors++; $display("FAIL redir_emit_flags: got %b want %b", flags, 5'b10100); end
    checks++; if ({inst, inst_pc} !== {32'h0010_0513, 32'h202}) begin errors++; $display("FAIL redir_emit_inst: got %h@%h want 00100513@00000202", inst, inst_pc); end
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL redir_empty: got %b want %b", flags, 5'b00000); end
  endtask

  task automatic test_illegal_backpressure();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 32'h0, 32'h300, 0);
      checks++; if (flags !== 5'b10110) begin errors++; $display("FAIL bp_hold%0d_flags: got %b want %b", i, flags, 5'b10110); end
      checks++; if (inst_pc !== 32'h300) begin errors++; $display("FAIL bp_hold%0d_pc: got %h want 00000300", i, inst_pc); end
    end
    drive(0, 0, 1, 32'h0, 32'h300, 1);
    checks++; if (flags !== 5'b11110) begin errors++; $display("FAIL bp_accept_flags: got %b want %b", flags, 5'b11110); end
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    checks++; if (flags !== 5'b10110) begin errors++; $display("FAIL bp_half_flags: got %b want %b", flags, 5'b10110); end
    checks++; if (inst_pc !== 32'h302) begin errors++; $display("FAIL bp_half_pc: got %h want 00000302", inst_pc); end
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL bp_empty: got %b want %b", flags, 5'b00000); end
  endtask

  task automatic test_flush_mid_straddle();
    drive(0, 0, 1, 32'h0513_4505, 32'h100, 1);
    checks++; if (flags !== 5'b11100) begin errors++; $display("FAIL fl_pre_flags: got %b want %b", flags, 5'b11100); end
    drive(0, 1, 1, 32'h4501_0010, 32'h104, 1);
    checks++; if (flags !== 5'b01000) begin errors++; $display("FAIL fl_flush_flags: got %b want %b", flags, 5'b01000); end
    drive(0, 0, 1, 32'h4505_4505, 32'h400, 1);
    checks++; if (flags !== 5'b11100) begin errors++; $display("FAIL fl_post0_flags: got %b want %b", flags, 5'b11100); end
    checks++; if ({inst, inst_pc} !== {32'h0010_0513, 32'h400}) begin errors++; $display("FAIL fl_post0_inst: got %h@%h want 00100513@00000400", inst, inst_pc); end
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    checks++; if ({inst, inst_pc} !== {32'h0010_0513, 32'h402}) begin errors++; $display("FAIL fl_post1_inst: got %h@%h want 00100513@00000402", inst, inst_pc); end
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL fl_empty: got %b want %b", flags, 5'b00000); end
  endtask

  task automatic test_rvc_expand();
    logic [15:0] par_tab [5] = '{16'h852E, 16'h4502, 16'h8082, 16'hA001, 16'h6501};
    logic [31:0] exp_tab [5] = '{32'h00B0_0533, 32'h0001_2503, 32'h0000_8067, 32'h0000_006F, 32'h0};
    logic        ill_tab [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] pc;
    for (int i = 0; i < 5; i++) begin
      pc = 32'h1000 + 32'(4 * i);
      drive(0, 0, 1, {16'h0001, par_tab[i]}, pc, 1);
      checks++; if (flags !== {3'b111, ill_tab[i], 1'b0}) begin errors++; $display("FAIL rvc%0d_flags: got %b want %b", i, flags, {3'b111, ill_tab[i], 1'b0}); end
      if (!ill_tab[i]) begin
        checks++; if ({inst, inst_pc} !== {exp_tab[i], pc}) begin errors++; $display("FAIL rvc%0d_inst: got %h@%h want %h@%h", i, inst, inst_pc, exp_tab[i], pc); end
      end
      drive(0, 0, 0, 32'h0, 32'h0, 1);
      checks++; if ({inst, inst_pc} !== {32'h0000_0013, pc + 32'd2}) begin errors++; $display("FAIL rvc%0d_nop: got %h@%h want 00000013@%h", i, inst, inst_pc, pc + 32'd2); end
    end
  endtask

  task automatic test_pc_wrap();
    drive(0, 0, 1, 32'h0513_FFFF, 32'hFFFF_FFFE, 1);
    checks++; if (flags !== 5'b01000) begin errors++; $display("FAIL wrap_dead_flags: got %b want %b", flags, 5'b01000); end
    drive(0, 0, 1, 32'h4501_0010, 32'h0000_0000, 1);
    checks++; if (flags !== 5'b11000) begin errors++; $display("FAIL wrap_strad_flags: got %b want %b", flags, 5'b11000); end
    checks++; if ({inst, inst_pc} !== {32'h0010_0513, 32'hFFFF_FFFE}) begin errors++; $display("FAIL wrap_strad_inst: got %h@%h want 00100513@fffffffe", inst, inst_pc); end
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    checks++; if ({inst, inst_pc} !== {32'h0000_0513, 32'h0000_0002}) begin errors++; $display("FAIL wrap_hi_inst: got %h@%h want 00000513@00000002", inst, inst_pc); end
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL wrap_empty: got %b want %b", flags, 5'b00000); end
  endtask

  task automatic test_seq_err_and_reset();
    drive(0, 0, 1, 32'h0513_4505, 32'h100, 1);
    checks++; if (flags !== 5'b11100) begin errors++; $display("FAIL seq_pre_flags: got %b want %b", flags, 5'b11100); end
    drive(0, 0, 1, 32'h4501_0010, 32'h108, 0);
    checks++; if (flags !== 5'b10001) begin errors++; $display("FAIL seq_err_flags: got %b want %b", flags, 5'b10001); end
    checks++; if ({inst, inst_pc} !== {32'h0010_0513, 32'h102}) begin errors++; $display("FAIL seq_err_inst: got %h@%h want 00100513@00000102", inst, inst_pc); end
    drive(1, 0, 1, 32'h4501_0010, 32'h108, 0);
    checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL seq_rst_flags: got %b want %b", flags, 5'b00000); end
    drive(0, 0, 1, 32'h0000_0513, 32'h500, 1);
    checks++; if (flags !== 5'b11000) begin errors++; $display("FAIL seq_post_flags: got %b want %b", flags, 5'b11000); end
    checks++; if ({inst, inst_pc} !== {32'h0000_0513, 32'h500}) begin errors++; $display("FAIL seq_post_inst: got %h@%h want 00000513@00000500", inst, inst_pc); end
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL seq_empty: got %b want %b", flags, 5'b00000); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_data = 32'h0; fetch_pc = 32'h0; inst_ready = 1'b0;
    test_reset();
    test_two_compressed();
    test_straddle();
    test_halfword_redirect();
    test_illegal_backpressure();
    test_flush_mid_straddle();
    test_rvc_expand();
    test_pc_wrap();
    test_seq_err_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
